// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : RV32 opcode/funct3 constants and immediate decoders       |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{21{instr[31]}}, instr[30:20]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_compare.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_compare : conditional-branch direction from funct3 and operands    |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module br_compare
  import riscv_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  output logic        taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = (rs1_i == rs2_i);
      F3_BNE:  taken_o = (rs1_i != rs2_i);
      F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: taken_o = (rs1_i <  rs2_i);
      F3_BGEU: taken_o = (rs1_i >= rs2_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/br_resolve_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_resolve_stage : EX slot, branch resolution, mispredict squash and  |
// |                    branch statistics                                  |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module br_resolve_stage
  import riscv_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instruction_i,
  input  logic             br_pred_i,
  input  logic [31:0]      pred_target_i,
  input  logic             stall_i,
  input  logic [31:0]      rs1_data_i,
  input  logic [31:0]      rs2_data_i,
  output logic             br_taken_o,
  output logic             br_pred_o,
  output logic [31:0]      new_pc_o,
  output logic             flush_o,
  output logic             ex_valid_o,
  output logic [31:0]      ex_pc_o,
  output logic [31:0]      ex_instr_o,
  output logic [31:0]      link_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_pc_q,    ex_pc_d;
  logic [31:0]      ex_instr_q, ex_instr_d;
  logic             ex_pred_q,  ex_pred_d;
  logic [31:0]      ex_ptgt_q,  ex_ptgt_d;
  logic [CNT_W-1:0] br_cnt_q,   br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [6:0]  opcode;
  logic        is_branch, is_jal, is_jalr, is_ctrl;
  logic        resolve_en, cmp_taken, taken, tgt_miss, pred_eff, flush;
  logic [31:0] seq_pc, jalr_sum, target;

  assign opcode     = ex_instr_q[6:0];
  assign is_branch  = (opcode == OP_BRANCH);
  assign is_jal     = (opcode == OP_JAL);
  assign is_jalr    = (opcode == OP_JALR);
  assign is_ctrl    = is_branch | is_jal | is_jalr;
  assign resolve_en = ex_valid_q & ~stall_i;
  assign seq_pc     = ex_pc_q + 32'd4;
  assign jalr_sum   = rs1_data_i + imm_i(ex_instr_q);

  br_compare u_br_compare (
    .rs1_i    (rs1_data_i),
    .rs2_i    (rs2_data_i),
    .funct3_i (ex_instr_q[14:12]),
    .taken_o  (cmp_taken)
  );

  always_comb begin
    target = seq_pc;
    if (is_branch)    target = ex_pc_q + imm_b(ex_instr_q);
    else if (is_jal)  target = ex_pc_q + imm_j(ex_instr_q);
    else if (is_jalr) target = {jalr_sum[31:1], 1'b0};
  end

  assign taken    = resolve_en & ((is_branch & cmp_taken) | is_jal | is_jalr);
  // A right-direction, wrong-target hit is reported as a direction miss so
  // fetch sees a mismatch and redirects.
  assign tgt_miss = taken & ex_pred_q & (ex_ptgt_q != target);
  assign pred_eff = resolve_en & ex_pred_q & ~tgt_miss;
  assign flush    = resolve_en & (taken ^ pred_eff);

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_instr_d = ex_instr_q;
    ex_pred_d  = ex_pred_q;
    ex_ptgt_d  = ex_ptgt_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (!stall_i) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = pc_i;
      ex_instr_d = instruction_i;
      ex_pred_d  = br_pred_i;
      ex_ptgt_d  = pred_target_i;
    end
    if (resolve_en && is_ctrl) br_cnt_d   = br_cnt_q + CNT_W'(1);
    if (flush)                 miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= RESET_PC;
      ex_instr_q <= NOP;
      ex_pred_q  <= 1'b0;
      ex_ptgt_q  <= 32'h0000_0000;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_instr_q <= ex_instr_d;
      ex_pred_q  <= ex_pred_d;
      ex_ptgt_q  <= ex_ptgt_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_taken_o = taken;
  assign br_pred_o  = pred_eff;
  assign new_pc_o   = taken ? target : seq_pc;
  assign flush_o    = flush;
  assign ex_valid_o = ex_valid_q;
  assign ex_pc_o    = ex_pc_q;
  assign ex_instr_o = ex_instr_q;
  assign link_o     = seq_pc;
  assign br_cnt_o   = br_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_br_resolve_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_br_resolve_stage : vector table + scoreboard bench for             |
// |                       br_resolve_stage                                |
// | Revision            : 1.0                                             |
// +----------------------------------------------------------------------+
module tb_br_resolve_stage;

  localparam int NV = 14;
  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_i, instruction_i, pred_target_i, rs1_data_i, rs2_data_i;
  logic        br_pred_i, stall_i;
  logic        br_taken_o, br_pred_o, flush_o, ex_valid_o;
  logic [31:0] new_pc_o, ex_pc_o, ex_instr_o, link_o;
  logic [31:0] br_cnt_o, miss_cnt_o;

  br_resolve_stage #(.CNT_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_i          (pc_i),
    .instruction_i (instruction_i),
    .br_pred_i     (br_pred_i),
    .pred_target_i (pred_target_i),
    .stall_i       (stall_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .br_taken_o    (br_taken_o),
    .br_pred_o     (br_pred_o),
    .new_pc_o      (new_pc_o),
    .flush_o       (flush_o),
    .ex_valid_o    (ex_valid_o),
    .ex_pc_o       (ex_pc_o),
    .ex_instr_o    (ex_instr_o),
    .link_o        (link_o),
    .br_cnt_o      (br_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic [31:0] ptgt;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        e_taken;
    logic        e_pred;
    logic        e_flush;
    logic [31:0] e_npc;
    logic        e_ctrl;
  } vec_t;

  vec_t tbl [NV];
  vec_t sbq [$];
  vec_t exp_v;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_br = 0, exp_miss = 0;
  logic        prev_flush = 1'b0;

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [31:0] imm);
    return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [31:0] imm);
    return {imm[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic pred, input logic [31:0] ptgt,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic et, input logic ep, input logic ef,
                              input logic [31:0] enpc, input logic ec);
    vec_t v;
    v.pc = pc; v.instr = instr; v.pred = pred; v.ptgt = ptgt;
    v.rs1 = rs1; v.rs2 = rs2; v.e_taken = et; v.e_pred = ep;
    v.e_flush = ef; v.e_npc = enpc; v.e_ctrl = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic pred, input logic [31:0] ptgt);
    pc_i = pc; instruction_i = instr; br_pred_i = pred; pred_target_i = ptgt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals;
    chk("rst_taken",  {31'b0, br_taken_o}, 32'd0);
    chk("rst_pred",   {31'b0, br_pred_o},  32'd0);
    chk("rst_flush",  {31'b0, flush_o},    32'd0);
    chk("rst_newpc",  new_pc_o,            32'h4);
    chk("rst_valid",  {31'b0, ex_valid_o}, 32'd0);
    chk("rst_expc",   ex_pc_o,             32'h0);
    chk("rst_instr",  ex_instr_o,          TB_NOP);
    chk("rst_link",   link_o,              32'h4);
    chk("rst_brcnt",  br_cnt_o,            32'd0);
    chk("rst_miss",   miss_cnt_o,          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(32'h100, enc_b(3'b000, 32'd16), 1'b0, 32'h0, 32'd5, 32'd5,
                 1, 0, 1, 32'h110, 1);
    tbl[1]  = mk(32'h200, enc_b(3'b110, 32'd16), 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1,
                 0, 0, 0, 32'h204, 1);
    tbl[2]  = mk(32'h200, enc_b(3'b100, 32'd16), 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1,
                 1, 0, 1, 32'h210, 1);
    tbl[3]  = mk(32'h300, enc_jalr(32'd4), 1'b1, 32'h1004, 32'h1001, 32'd0,
                 1, 1, 0, 32'h1004, 1);
    tbl[4]  = mk(32'h300, enc_jalr(32'd4), 1'b1, 32'h2000, 32'h1001, 32'd0,
                 1, 0, 1, 32'h1004, 1);
    tbl[5]  = mk(32'h400, enc_b(3'b001, 32'hFFFF_FFF8), 1'b1, 32'h3F8, 32'd3, 32'd4,
                 1, 1, 0, 32'h3F8, 1);
    tbl[6]  = mk(32'h500, enc_b(3'b101, 32'h20), 1'b1, 32'h520, 32'h8000_0000, 32'd0,
                 0, 1, 1, 32'h504, 1);
    tbl[7]  = mk(32'h500, enc_b(3'b111, 32'h20), 1'b1, 32'h520, 32'h8000_0000, 32'd0,
                 1, 1, 0, 32'h520, 1);
    tbl[8]  = mk(32'h600, enc_b(3'b010, 32'h20), 1'b0, 32'h0, 32'd1, 32'd1,
                 0, 0, 0, 32'h604, 1);
    tbl[9]  = mk(32'h700, enc_j(32'hFFFF_FF00), 1'b0, 32'h0, 32'd0, 32'd0,
                 1, 0, 1, 32'h600, 1);
    tbl[10] = mk(32'hFFFF_FFF0, enc_j(32'h20), 1'b1, 32'h10, 32'd0, 32'd0,
                 1, 1, 0, 32'h10, 1);
    tbl[11] = mk(32'h800, enc_addi(32'd7), 1'b1, 32'h900, 32'd0, 32'd0,
                 0, 1, 1, 32'h804, 0);
    tbl[12] = mk(32'h804, enc_addi(32'd7), 1'b0, 32'h0, 32'd0, 32'd0,
                 0, 0, 0, 32'h808, 0);
    tbl[13] = mk(32'h840, enc_b(3'b000, 32'h40), 1'b1, 32'h880, 32'd1, 32'd2,
                 0, 1, 1, 32'h844, 1);

    reset_n = 1'b0;
    stall_i = 1'b0;
    rs1_data_i = 0; rs2_data_i = 0;
    drive(32'h0, TB_NOP, 1'b0, 32'h0);
    tick; tick;
    chk_reset_vals();
    reset_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      drive(32'h0, TB_NOP, 1'b0, 32'h0);
      tick;
      chk("squash_valid", {31'b0, ex_valid_o}, {31'b0, ~prev_flush});
      drive(tbl[k].pc, tbl[k].instr, tbl[k].pred, tbl[k].ptgt);
      rs1_data_i = tbl[k].rs1;
      rs2_data_i = tbl[k].rs2;
      sbq.push_back(tbl[k]);
      tick;
      exp_v = sbq.pop_front();
      chk("vec_valid", {31'b0, ex_valid_o}, 32'd1);
      chk("vec_expc",  ex_pc_o,             exp_v.pc);
      chk("vec_taken", {31'b0, br_taken_o}, {31'b0, exp_v.e_taken});
      chk("vec_pred",  {31'b0, br_pred_o},  {31'b0, exp_v.e_pred});
      chk("vec_flush", {31'b0, flush_o},    {31'b0, exp_v.e_flush});
      chk("vec_newpc", new_pc_o,            exp_v.e_npc);
      chk("vec_link",  link_o,              exp_v.pc + 32'd4);
      chk("vec_brcnt", br_cnt_o,            exp_br);
      chk("vec_miss",  miss_cnt_o,          exp_miss);
      exp_br     = exp_br + {31'b0, exp_v.e_ctrl};
      exp_miss   = exp_miss + {31'b0, exp_v.e_flush};
      prev_flush = exp_v.e_flush;
    end

    drive(32'h0, TB_NOP, 1'b0, 32'h0);
    tick;
    chk("squash_valid", {31'b0, ex_valid_o}, {31'b0, ~prev_flush});
    chk("tbl_brcnt", br_cnt_o,   exp_br);
    chk("tbl_miss",  miss_cnt_o, exp_miss);

    // Mispredicting BEQ held under a three-cycle stall.
    drive(32'h900, enc_b(3'b000, 32'd8), 1'b0, 32'h0);
    rs1_data_i = 32'd7; rs2_data_i = 32'd7;
    tick;
    stall_i = 1'b1;
    drive(32'h904, enc_addi(32'd1), 1'b0, 32'h0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_flush", {31'b0, flush_o},    32'd0);
      chk("stall_taken", {31'b0, br_taken_o}, 32'd0);
      chk("stall_expc",  ex_pc_o,             32'h900);
      chk("stall_valid", {31'b0, ex_valid_o}, 32'd1);
      chk("stall_newpc", new_pc_o,            32'h904);
      chk("stall_brcnt", br_cnt_o,            exp_br);
      tick;
    end
    stall_i = 1'b0;
    #1;
    chk("unstall_flush", {31'b0, flush_o},    32'd1);
    chk("unstall_taken", {31'b0, br_taken_o}, 32'd1);
    chk("unstall_newpc", new_pc_o,            32'h908);
    tick;
    exp_br = exp_br + 1; exp_miss = exp_miss + 1;
    chk("unstall_squash", {31'b0, ex_valid_o}, 32'd0);
    chk("unstall_brcnt",  br_cnt_o,            exp_br);
    chk("unstall_miss",   miss_cnt_o,          exp_miss);

    // Straight-line ADDI stream.
    for (int i = 0; i < 6; i++) begin
      drive(32'hA00 + 32'(4 * i), enc_addi(32'(i)), 1'b0, 32'h0);
      tick;
      chk("addi_expc",  ex_pc_o,          32'hA00 + 32'(4 * i));
      chk("addi_newpc", new_pc_o,         32'hA04 + 32'(4 * i));
      chk("addi_flush", {31'b0, flush_o}, 32'd0);
      chk("addi_brcnt", br_cnt_o,         exp_br);
      chk("addi_miss",  miss_cnt_o,       exp_miss);
    end

    // Asynchronous reset asserted while a flush is being signalled.
    drive(32'hB00, enc_j(32'h40), 1'b0, 32'h0);
    tick;
    chk("preflush", {31'b0, flush_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/br_resolve_stage.md
Name: br_resolve_stage

Overview:
- Execute-side end of the fetch prediction interface. Latches each fetched instruction together with its branch prediction into the EX slot.
- Resolves the actual branch direction and target, and returns the taken flag, the prediction and the corrected PC to fetch.
- Squashes the wrong-path instruction on a mispredict and keeps branch/mispredict statistics.

Parameters:
CNT_W, 32, width of the branch and mispredict statistics counters (wrap-around)
RESET_PC, 32'h0000_0000, value of ex_pc_o after reset

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
pc_i  in  32  PC of the instruction fetched this cycle
instruction_i  in  32  instruction fetched this cycle
br_pred_i  in  1  fetch prediction for pc_i (1 = taken)
pred_target_i  in  32  fetch predicted target for pc_i
stall_i  in  1  pipeline stall; hold the EX slot, no resolution
rs1_data_i  in  32  rs1 operand for the EX instruction (already forwarded)
rs2_data_i  in  32  rs2 operand for the EX instruction
br_taken_o  out  1  resolved direction of the EX instruction
br_pred_o  out  1  effective prediction of the EX instruction
new_pc_o  out  32  correct next PC for the EX instruction
flush_o  out  1  mispredict detected this cycle
ex_valid_o  out  1  EX slot holds a live instruction
ex_pc_o  out  32  PC in EX slot
ex_instr_o  out  32  instruction in EX slot
link_o  out  32  ex_pc_o+4, write-back value for JAL/JALR
br_cnt_o  out  CNT_W  resolved control-transfer instructions
miss_cnt_o  out  CNT_W  mispredicts

Behaviour:
- Reset (async, reset_n=0) sets all state immediately:
  - ex_valid=0, ex_pc=RESET_PC, ex_instr=32'h0000_0013 (NOP).
  - ex_pred=0, ex_ptgt=0, counters=0.
- Reset-derived outputs: br_taken_o=0, br_pred_o=0, flush_o=0, new_pc_o=RESET_PC+4.
- Reset mid-flush or mid-stall discards everything.
- resolve_en = ex_valid & ~stall_i. All resolution outputs are combinational from the EX slot and the operands, with zero latency.
- When resolve_en=0: br_taken_o=0, br_pred_o=0, flush_o=0 (so fetch never sees a mismatch). new_pc_o = ex_pc+4.
- Instruction classes (opcode):
  - 1100011 branch: taken per funct3 — 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE. funct3 010/011 = not taken. Target = ex_pc + sext(B-imm).
  - 1101111 JAL: always taken. Target = ex_pc + sext(J-imm).
  - 1100111 JALR: always taken. Target = (rs1 + sext(I-imm)) & ~1.
  - Anything else: not a control transfer; taken=0.
- new_pc_o = target if taken, else ex_pc+4. All adds are modulo 2^32.
- br_taken_o = taken.
- br_pred_o = ex_pred, except: taken & ex_pred & (ex_ptgt != target) forces br_pred_o=0. This exposes a wrong-target hit as a direction mismatch at fetch.
- flush_o = resolve_en & (br_taken_o != br_pred_o).
- EX slot update at rising clk, in priority order:
  - flush_o → ex_valid=0 (squash the wrong-path instruction present on the inputs); ex_pc/ex_instr are don't-care.
  - stall_i → hold all slot registers.
  - else → capture pc_i, instruction_i, br_pred_i, pred_target_i and set ex_valid=1.
  - Flush and stall cannot coincide, since resolve_en excludes stall.
- Counters:
  - br_cnt increments on resolve_en & control-transfer.
  - miss_cnt increments on flush_o.
  - Both wrap at 2^CNT_W.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - funct3 constants F3_BEQ..F3_BGEU.
  - NOP constant.
  - immediate-extraction functions imm_b, imm_j, imm_i.
- One combinational sub-module br_compare (rs1, rs2, funct3 → taken) holds the six comparisons and the illegal-funct3 rule.
- Slot register, target generation, override logic and counters stay in br_resolve_stage.

Test Plan:
- Reset with reset_n low mid-cycle → all outputs at reset values immediately, asynchronously: new_pc_o=32'h4, counters 0.
- BEQ (funct3 000) at pc 0x100, imm +16, rs1=rs2=5, br_pred_i=0 → next cycle: br_taken_o=1, flush_o=1, new_pc_o=0x110, miss_cnt=1; instruction captured the following edge has ex_valid_o=0.
- BLTU at 0x200, rs1=0xFFFF_FFFF, rs2=1, predicted not taken → br_taken_o=0, flush_o=0, new_pc_o=0x204, br_cnt=1. Repeat as BLT → taken.
- JALR at 0x300, rs1=0x1001, imm 4, predicted taken with pred_target 0x1004 → target 0x1004, no flush. With pred_target 0x2000 → br_pred_o=0, flush_o=1, new_pc_o=0x1004.
- Mispredicting branch in EX with stall_i=1 for 3 cycles → flush_o=0 and slot held throughout; flush_o=1 on the first cycle stall_i=0; counters increment once.
- Non-branch ADDI stream with br_pred_i=0 → flush_o never set, br_cnt stays 0, new_pc_o = ex_pc+4 each cycle.
